alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one ALU between two operation requesters, e.g. two UART-to-ALU command interfaces or a command interface plus a self-test sequencer. Each requester holds a level request with opcode and operands. The block grants requests round-robin, latches the operands and drives the ALU. It waits a parameterised ALU latency, captures the result and returns it to the granted requester with a one-cycle done pulse. It sits between the requesters and the ALU and is the only driver of the ALU operand inputs.

Parameters:
NB_DATA, 8, width of operands and result
NB_OP, 6, opcode width
ALU_LATENCY, 0, cycles from operands driven to result valid on i_alu_result (range 0..15; 0 = combinational ALU)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_req0  in  1  requester 0 level request; hold until o_done0
i_op0  in  NB_OP  requester 0 opcode; stable while i_req0=1
i_dataA0  in  NB_DATA  requester 0 operand A
i_dataB0  in  NB_DATA  requester 0 operand B
o_gnt0  out  1  one-cycle pulse: requester 0 operands latched
o_done0  out  1  one-cycle pulse: o_result valid for requester 0
i_req1, i_op1, i_dataA1, i_dataB1, o_gnt1, o_done1: same as above, for requester 1
o_alu_op  out  NB_OP  registered opcode to the ALU
o_alu_dataA  out  NB_DATA  registered operand A to the ALU
o_alu_dataB  out  NB_DATA  registered operand B to the ALU
i_alu_result  in  NB_DATA  ALU result
o_result  out  NB_DATA  captured result; holds until the next capture
o_busy  out  1  1 in any state other than IDLE
o_last_grant  out  1  index of the most recently granted requester

Behaviour:
- Reset: all outputs 0 except o_last_grant=1, so requester 0 wins the first tie. State returns to IDLE. The latency counter and grant index clear.
- Reset mid-operation aborts the operation. No done pulse is issued and the result is discarded.
- States: IDLE, EXEC, RESP. All outputs are registered.
- IDLE: sample i_req0 and i_req1.
  - One request high: grant that requester.
  - Both high: grant the requester whose index is not o_last_grant.
  - On a grant at edge k:
    - latch op/A/B into the o_alu_* registers;
    - set gnt_idx;
    - update o_last_grant;
    - pulse o_gnt<idx> for one cycle (high during cycle k+1);
    - load the latency counter with ALU_LATENCY;
    - go to EXEC.
  - No request: stay in IDLE; o_alu_* hold their last values (not cleared).
- EXEC:
  - counter != 0: decrement.
  - counter == 0: capture i_alu_result into o_result and go to RESP.
- RESP: o_done<gnt_idx>=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency: request first sampled at edge k. Then:
  - o_gnt is high during cycle k+1;
  - o_result capture occurs at edge k+1+ALU_LATENCY;
  - o_done is high during cycle k+2+ALU_LATENCY.
  - Throughput: one operation per 3+ALU_LATENCY cycles.
- Requester rule: deassert req at the edge where o_done=1 is sampled. A req still high in the following IDLE cycle is treated as a new request.
- Requests arriving while busy wait, with no loss, because requests are level. Operand changes while a requester is not granted have no effect.
- A starvation bound follows from alternation on ties. A continuously requesting requester is granted within 2 operations.
- o_gnt and o_done never assert for both requesters in the same cycle. o_gnt and o_done are never both high in the same cycle.
- Arithmetic: no width conversion; the result is passed through unmodified.

Decomposition:
- Shared package, alu_share_pkg:
  - state encodings IDLE=2'b00, EXEC=2'b01, RESP=2'b10; unused encodings recover to IDLE;
  - ALU opcode constants ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, used by the bench.
- One natural sub-module: rr_pick2. It is combinational, with inputs req0, req1, last and outputs valid, idx, and it is reused by other two-way arbiters.

Test Plan:
- Reset, then i_req0=1 with ADD, A=8'h05, B=8'h03, ALU_LATENCY=0, reference ALU -> o_gnt0 at cycle 1, o_done0 at cycle 2, o_result=8'h08; o_gnt1 and o_done1 stay 0.
- Both requests high at once: req0 SUB A=8'h0A B=8'h04, req1 ADD A=8'h01 B=8'h01 -> requester 0 served first with result 8'h06, then requester 1 with 8'h02; o_last_grant ends at 1.
- Both requests held high continuously for 6 operations -> grants strictly alternate 0,1,0,1,0,1; no two consecutive grants to the same index.
- ALU_LATENCY=3 with a delay-line ALU, req1 OR A=8'hF0 B=8'h0F -> o_done1 at cycle 5, o_result=8'hFF, o_busy high for cycles 1-5.
- Assert i_reset during EXEC -> no o_done pulse; all outputs 0 and o_last_grant=1 the next cycle; a subsequent request completes normally.
- req1 raised while requester 0 is in EXEC, with i_dataA1 changed mid-wait -> requester 1 is granted in the IDLE cycle after requester 0's RESP, using the operand values present at its grant edge.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_pkg
//  Description : Shared types and constants for the ALU share arbiter:
//                FSM state encoding and the ALU opcode values.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_share_pkg;

    // FSM state encoding; the fourth code (2'b11) is unused and recovers to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // ALU opcodes understood by the shared ALU
    localparam logic [5:0] c_op_add = 6'b100000;
    localparam logic [5:0] c_op_sub = 6'b100010;
    localparam logic [5:0] c_op_and = 6'b100100;
    localparam logic [5:0] c_op_or  = 6'b100101;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way round-robin picker. When both
//                requests are high, the requester that was not granted last
//                wins; otherwise the single active requester wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic idx
);

    // Pick a winner: alternate on ties, otherwise take whoever is asking
    always_comb begin
        valid = req0 | req1;
        idx   = (req0 & req1) ? ~last : req1;
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one ALU between two level-request command sources.
//                Grants round-robin, drives registered operands to the ALU,
//                waits ALU_LATENCY cycles, captures the result and returns it
//                with a one-cycle done pulse to the granted requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int ALU_LATENCY = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_req0,
    input  logic [NB_OP-1:0]   i_op0,
    input  logic [NB_DATA-1:0] i_dataA0,
    input  logic [NB_DATA-1:0] i_dataB0,
    output logic               o_gnt0,
    output logic               o_done0,
    input  logic               i_req1,
    input  logic [NB_OP-1:0]   i_op1,
    input  logic [NB_DATA-1:0] i_dataA1,
    input  logic [NB_DATA-1:0] i_dataB1,
    output logic               o_gnt1,
    output logic               o_done1,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_alu_dataA,
    output logic [NB_DATA-1:0] o_alu_dataB,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_busy,
    output logic               o_last_grant
);

    import alu_share_pkg::*;

    localparam logic [3:0] c_latency = 4'(ALU_LATENCY);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_gnt_idx;

    logic               w_valid;
    logic               w_idx;
    logic [NB_OP-1:0]   w_op;
    logic [NB_DATA-1:0] w_dataA;
    logic [NB_DATA-1:0] w_dataB;

    rr_pick2 u_rr_pick2 (
        .req0  (i_req0),
        .req1  (i_req1),
        .last  (o_last_grant),
        .valid (w_valid),
        .idx   (w_idx)
    );

    // Select the operand set of the requester the picker would grant
    always_comb begin
        w_op    = w_idx ? i_op1    : i_op0;
        w_dataA = w_idx ? i_dataA1 : i_dataA0;
        w_dataB = w_idx ? i_dataB1 : i_dataB0;
    end

    // Arbitration FSM: grant in IDLE, count latency in EXEC, signal done in RESP
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_gnt_idx    <= 1'b0;
            o_gnt0       <= 1'b0;
            o_gnt1       <= 1'b0;
            o_done0      <= 1'b0;
            o_done1      <= 1'b0;
            o_alu_op     <= '0;
            o_alu_dataA  <= '0;
            o_alu_dataB  <= '0;
            o_result     <= '0;
            o_busy       <= 1'b0;
            o_last_grant <= 1'b1;
        end else begin
            // Grant and done are single-cycle pulses
            o_gnt0  <= 1'b0;
            o_gnt1  <= 1'b0;
            o_done0 <= 1'b0;
            o_done1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Operand registers keep their last values when nobody asks
                    if (w_valid) begin
                        o_alu_op     <= w_op;
                        o_alu_dataA  <= w_dataA;
                        o_alu_dataB  <= w_dataB;
                        r_gnt_idx    <= w_idx;
                        o_last_grant <= w_idx;
                        o_gnt0       <= ~w_idx;
                        o_gnt1       <= w_idx;
                        r_cnt        <= c_latency;
                        o_busy       <= 1'b1;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        o_result <= i_alu_result;
                        o_done0  <= ~r_gnt_idx;
                        o_done1  <= r_gnt_idx;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Self-checking bench for alu_share_arbiter. Two instances:
//                index 0 with a combinational ALU (latency 0), index 1 with a
//                three-stage delay-line ALU (latency 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    import alu_share_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic       req0  [2];
    logic       req1  [2];
    logic [5:0] op0   [2];
    logic [5:0] op1   [2];
    logic [7:0] a0    [2];
    logic [7:0] b0    [2];
    logic [7:0] a1    [2];
    logic [7:0] b1    [2];
    logic       gnt0  [2];
    logic       gnt1  [2];
    logic       done0 [2];
    logic       done1 [2];
    logic       busy  [2];
    logic       lastg [2];
    logic [5:0] alu_op[2];
    logic [7:0] alu_a [2];
    logic [7:0] alu_b [2];
    logic [7:0] result[2];

    logic [7:0] alu_res_l0;
    logic [7:0] alu_res_l3;
    logic [7:0] pipe  [3];

    int errors = 0;
    int checks = 0;
    int last_m [2];
    logic [5:0] last_op_m [2];

    function automatic logic [7:0] alu_fn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            c_op_add: return a + b;
            c_op_sub: return a - b;
            c_op_and: return a & b;
            c_op_or:  return a | b;
            default:  return a ^ b;
        endcase
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Reference ALUs: combinational, and a delay line of three registers
    always_comb alu_res_l0 = alu_fn(alu_op[0], alu_a[0], alu_b[0]);
    always @(posedge clk) begin
        pipe[0] <= alu_fn(alu_op[1], alu_a[1], alu_b[1]);
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign alu_res_l3 = pipe[2];

    alu_share_arbiter #(.NB_DATA(8), .NB_OP(6), .ALU_LATENCY(0)) u_dut_l0 (
        .i_clk(clk), .i_reset(rst[0]),
        .i_req0(req0[0]), .i_op0(op0[0]), .i_dataA0(a0[0]), .i_dataB0(b0[0]),
        .o_gnt0(gnt0[0]), .o_done0(done0[0]),
        .i_req1(req1[0]), .i_op1(op1[0]), .i_dataA1(a1[0]), .i_dataB1(b1[0]),
        .o_gnt1(gnt1[0]), .o_done1(done1[0]),
        .o_alu_op(alu_op[0]), .o_alu_dataA(alu_a[0]), .o_alu_dataB(alu_b[0]),
        .i_alu_result(alu_res_l0), .o_result(result[0]),
        .o_busy(busy[0]), .o_last_grant(lastg[0])
    );

    alu_share_arbiter #(.NB_DATA(8), .NB_OP(6), .ALU_LATENCY(3)) u_dut_l3 (
        .i_clk(clk), .i_reset(rst[1]),
        .i_req0(req0[1]), .i_op0(op0[1]), .i_dataA0(a0[1]), .i_dataB0(b0[1]),
        .o_gnt0(gnt0[1]), .o_done0(done0[1]),
        .i_req1(req1[1]), .i_op1(op1[1]), .i_dataA1(a1[1]), .i_dataB1(b1[1]),
        .o_gnt1(gnt1[1]), .o_done1(done1[1]),
        .o_alu_op(alu_op[1]), .o_alu_dataA(alu_a[1]), .o_alu_dataB(alu_b[1]),
        .i_alu_result(alu_res_l3), .o_result(result[1]),
        .o_busy(busy[1]), .o_last_grant(lastg[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 3))
            0:       return c_op_add;
            1:       return c_op_sub;
            2:       return c_op_and;
            default: return c_op_or;
        endcase
    endfunction

    task automatic rand_ops(input int d, input int r);
        if (r == 0) begin
            op0[d] = pick_op(); a0[d] = 8'($urandom); b0[d] = 8'($urandom);
        end else begin
            op1[d] = pick_op(); a1[d] = 8'($urandom); b1[d] = 8'($urandom);
        end
    endtask

    task automatic chk_reset(input int d);
        chk("rst_pulses", {gnt0[d], gnt1[d], done0[d], done1[d]}, 0);
        chk("rst_busy",   busy[d],   0);
        chk("rst_last",   lastg[d],  1);
        chk("rst_result", result[d], 0);
        chk("rst_alu",    {alu_op[d], alu_a[d], alu_b[d]}, 0);
    endtask

    task automatic do_reset(input int d);
        req0[d] = 1'b0; req1[d] = 1'b0; rst[d] = 1'b1;
        @(negedge clk);
        chk_reset(d);
        rst[d] = 1'b0;
        last_m[d] = 1;
        last_op_m[d] = '0;
    endtask

    // One operation, from an IDLE-cycle negedge with requests set up to the
    // next IDLE-cycle negedge. Expected winner comes from the tie-alternation rule.
    task automatic serve(input int d, input bit raise_other);
        int idx;
        int oth;
        logic [5:0] eop;
        logic [7:0] ea, eb, eres;
        if (req0[d] && req1[d]) idx = 1 - last_m[d];
        else                    idx = req1[d] ? 1 : 0;
        eop  = (idx == 1) ? op1[d] : op0[d];
        ea   = (idx == 1) ? a1[d]  : a0[d];
        eb   = (idx == 1) ? b1[d]  : b0[d];
        eres = alu_fn(eop, ea, eb);
        last_m[d] = idx;
        last_op_m[d] = eop;
        oth = 1 - idx;
        @(negedge clk);
        chk("gnt0",      gnt0[d],  32'(idx == 0));
        chk("gnt1",      gnt1[d],  32'(idx == 1));
        chk("gnt_done",  {done0[d], done1[d]}, 0);
        chk("gnt_busy",  busy[d],  1);
        chk("gnt_last",  lastg[d], 32'(idx));
        chk("gnt_alu",   {alu_op[d], alu_a[d], alu_b[d]}, {eop, ea, eb});
        if (raise_other) begin
            if (oth == 0) req0[d] = 1'b1; else req1[d] = 1'b1;
            rand_ops(d, oth);
        end
        repeat (lat(d)) begin
            @(negedge clk);
            chk("wait_pulses", {gnt0[d], gnt1[d], done0[d], done1[d]}, 0);
            chk("wait_busy",   busy[d], 1);
            if (raise_other) begin
                if (oth == 0) a0[d] = 8'($urandom); else a1[d] = 8'($urandom);
            end
        end
        @(negedge clk);
        chk("done0",       done0[d], 32'(idx == 0));
        chk("done1",       done1[d], 32'(idx == 1));
        chk("done_gnt",    {gnt0[d], gnt1[d]}, 0);
        chk("done_result", result[d], eres);
        chk("done_busy",   busy[d], 1);
        @(negedge clk);
        chk("idle_pulses", {gnt0[d], gnt1[d], done0[d], done1[d]}, 0);
        chk("idle_busy",   busy[d], 0);
        chk("idle_result", result[d], eres);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req0[d] = 1'b0; req1[d] = 1'b0;
            op0[d] = '0; op1[d] = '0; a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0;
            last_m[d] = 1; last_op_m[d] = '0;
        end
        repeat (2) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Single ADD on the combinational instance
        op0[0] = c_op_add; a0[0] = 8'h05; b0[0] = 8'h03; req0[0] = 1'b1;
        serve(0, 1'b0);
        chk("t1_result", result[0], 8'h08);
        req0[0] = 1'b0;

        // Simultaneous requests from reset: requester 0 first, then 1
        do_reset(0);
        op0[0] = c_op_sub; a0[0] = 8'h0A; b0[0] = 8'h04; req0[0] = 1'b1;
        op1[0] = c_op_add; a1[0] = 8'h01; b1[0] = 8'h01; req1[0] = 1'b1;
        serve(0, 1'b0);
        chk("t2_first", result[0], 8'h06);
        req0[0] = 1'b0;
        serve(0, 1'b0);
        chk("t2_second", result[0], 8'h02);
        chk("t2_last", lastg[0], 1);
        req1[0] = 1'b0;

        // Both held continuously: strict alternation 0,1,0,1,0,1
        rand_ops(0, 0); rand_ops(0, 1);
        req0[0] = 1'b1; req1[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            serve(0, 1'b0);
            chk("t3_alt", lastg[0], 32'(i % 2));
            rand_ops(0, last_m[0]);
        end
        req0[0] = 1'b0; req1[0] = 1'b0;

        // No request: stays idle, ALU operands hold
        repeat (3) begin
            @(negedge clk);
            chk("noreq_busy", {busy[0], gnt0[0], gnt1[0]}, 0);
            chk("noreq_hold", alu_op[0], last_op_m[0]);
        end

        // Latency 3: OR F0|0F to requester 1
        do_reset(1);
        op1[1] = c_op_or; a1[1] = 8'hF0; b1[1] = 8'h0F; req1[1] = 1'b1;
        serve(1, 1'b0);
        chk("t4_result", result[1], 8'hFF);
        req1[1] = 1'b0;

        // Reset during EXEC aborts the operation
        rand_ops(1, 0); req0[1] = 1'b1;
        @(negedge clk);
        chk("t5_gnt", gnt0[1], 1);
        rst[1] = 1'b1;
        @(negedge clk);
        chk_reset(1);
        req0[1] = 1'b0; rst[1] = 1'b0; last_m[1] = 1;
        @(negedge clk);
        chk("t5_nodone", {done0[1], done1[1], busy[1]}, 0);
        rand_ops(1, 1); req1[1] = 1'b1;
        serve(1, 1'b0);
        req1[1] = 1'b0;

        // Requester 1 raised while 0 executes, operand A changed during the wait
        rand_ops(1, 0); req0[1] = 1'b1;
        serve(1, 1'b1);
        req0[1] = 1'b0;
        chk("t6_pending", req1[1], 1);
        serve(1, 1'b0);
        chk("t6_last", lastg[1], 1);
        req1[1] = 1'b0;

        // Randomized request patterns on both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 12; i++) begin
                int r;
                r = $urandom_range(1, 3);
                req0[d] = r[0]; req1[d] = r[1];
                rand_ops(d, 0); rand_ops(d, 1);
                serve(d, 1'($urandom_range(0, 1)));
            end
            req0[d] = 1'b0; req1[d] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
